load_store_unit: RTL and testbench
==================================

# load_store_unit

Multi-cycle data-memory access unit for the RISC-V core. It takes load/store requests from the control path and the ALU-computed address, and runs a req/ack handshake on the data bus. Stores get byte-lane enables and replicated write data; load data is aligned and sign/zero-extended. The registered load result drives data input 1 of the write-back 3-to-1 multiplexer, and `Stall_o` freezes the PC until the access completes.

## Interface
- `NBits`, 32: data and address width; only 32 is supported.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `Mem_Read_i`  in  1  load request; held by the core while `Stall_o`=1.
- `Mem_Write_i`  in  1  store request; held likewise.
- `Funct3_i`  in  3  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only).
- `Address_i`  in  NBits  byte address from the ALU.
- `Write_Data_i`  in  NBits  store data (rs2).
- `Stall_o`  out  1  high while an access is pending.
- `Load_Data_o`  out  NBits  extended load result to the write-back mux.
- `Access_Fault_o`  out  1  one-cycle flag: misaligned or illegal access; no bus cycle is issued.
- `Bus_Req_o`  out  1  bus request.
- `Bus_We_o`  out  1  1 = write.
- `Bus_Addr_o`  out  NBits  word-aligned address (`Address_i` with [1:0]=00).
- `Bus_Wdata_o`  out  NBits  lane-replicated store data.
- `Bus_Be_o`  out  4  byte enables.
- `Bus_Ack_i`  in  1  completion; read data is valid in the same cycle.
- `Bus_Rdata_i`  in  NBits  read word.

## Operation
- **FSM states:** IDLE, REQ, DONE. Reset state is IDLE.
- **Reset values:** all registered outputs 0, including `Bus_Req_o`, `Bus_We_o`, `Bus_Addr_o`, `Bus_Wdata_o`, `Bus_Be_o` and `Load_Data_o`.
- **Legal access:** exactly one of `Mem_Read_i`/`Mem_Write_i` is high, and `Funct3_i` is valid for the direction.
- **Alignment:** H/HU need addr[0]=0; W needs addr[1:0]=00.
- **IDLE:**
  - Legal, aligned access: register address, byte enables, write data and type, then go to REQ.
  - Otherwise, if any request is high: assert `Access_Fault_o` combinationally and stay in IDLE.
  - Faulting cases include both requests high, an illegal `Funct3_i`, and misalignment.
- **REQ:** `Bus_Req_o`=1, with address, we, be and wdata stable. On `Bus_Ack_i`=1:
  - Loads: capture the extended data into `Load_Data_o`.
  - Go to DONE.
- **DONE:** one cycle, then IDLE unconditionally.
- **Stall_o (combinational):**
  - 1 in REQ.
  - 1 in IDLE when a legal, aligned access is requested.
  - 0 in DONE, and 0 on a fault.
- **Store lanes, with off = addr[1:0]:**
  - B: be = 0001<<off, wdata = {4{rs2[7:0]}}.
  - H: be = 0011<<off, wdata = {2{rs2[15:0]}}.
  - W: be = 1111, wdata = rs2.
- **Load extraction:**
  - Byte: rdata[8*off+7 : 8*off]. Half: rdata[8*off+15 : 8*off].
  - B/H sign-extend; BU/HU zero-extend; W passes through.
- `Load_Data_o` holds its value until the next load completes. Stores and faults do not change it.
- `Bus_Ack_i` outside REQ is ignored.
- A bus transaction, once in REQ, completes even if the requests drop.

## Timing
- Minimum access time: 3 cycles (IDLE→REQ→DONE) with ack in the first REQ cycle. Each ack-wait cycle adds one.
- The PC advances on the clock edge that ends DONE.
- `Load_Data_o` is valid from the DONE cycle onward, in time for the write-back mux and register write in that cycle.
- **Reset mid-REQ:** `Bus_Req_o` falls asynchronously, the state returns to IDLE, and the access is abandoned.
- A fault costs zero stall cycles: the instruction retires in the cycle the fault is flagged.
- **Back-to-back accesses:**
  - The next instruction's request can be accepted in the IDLE cycle that follows DONE.
  - There is no bus-idle cycle requirement beyond that.

## Structure
- Package `lsu_pkg`:
  - Funct3 constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`).
  - FSM state encoding (2-bit, IDLE=00, REQ=01, DONE=10).
- Sub-module `load_extender`: combinational lane select plus sign/zero extension, with inputs rdata, off and funct3. It is reused in the LSU only.
- The FSM, request registers and store-lane logic live in `load_store_unit`.

## Test plan
- **LW aligned:** addr 0x100, ack after 2 wait cycles, rdata 0xDEADBEEF.
  - `Stall_o` is high for 4 cycles, `Bus_Addr_o`=0x100, `Bus_Be_o`=1111.
  - `Load_Data_o`=0xDEADBEEF in DONE.
- **LB / LBU:** addr 0x103, rdata 0x80112233.
  - LB gives 0xFFFFFF80; LBU gives 0x00000080.
  - `Bus_Addr_o`=0x100.
- **SH:** addr 0x202, rs2 0x1234ABCD.
  - `Bus_Be_o`=1100, `Bus_Wdata_o`=0xABCDABCD, `Bus_We_o`=1.
  - `Load_Data_o` is unchanged.
- **Faults:**
  - LW at 0x101: `Access_Fault_o`=1 for 1 cycle, `Bus_Req_o` stays 0, `Stall_o`=0.
  - Same response for LH at 0x3, for funct3=110 load, and with both requests high.
- **Reset asserted in REQ before ack:**
  - `Bus_Req_o` drops without waiting for a clock edge; the state is IDLE.
  - `Load_Data_o`=0; a later ack is ignored.
- **Back-to-back:** SW then LHU at 0x6 with ack in the first cycle.
  - Each takes 3 cycles.
  - LHU with rdata 0xF00D0000 gives 0x0000F00D.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - Funct3 access-type encodings (RISC-V load/store width field).
//   - FSM state encoding for the bus handshake.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StReq  = 2'b01,
    StDone = 2'b10
  } lsu_state_e;

endpackage

// File: rtl/load_extender.sv
// load_extender: picks the addressed byte/half out of a bus read word and
// sign- or zero-extends it according to funct3. Purely combinational.
//   rdata   in   32  word returned by the data bus
//   off     in    2  byte offset within the word (addr[1:0])
//   funct3  in    3  access type (B, H, W, BU, HU)
//   ext     out  32  aligned, extended load result
module load_extender
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    unique case (off)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    // Halfword accesses are aligned, so only off[1] matters.
    half_sel = off[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    ext = rdata;
    case (funct3)
      F3_B:    ext = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    ext = {{16{half_sel[15]}}, half_sel};
      F3_BU:   ext = {24'h0, byte_sel};
      F3_HU:   ext = {16'h0, half_sel};
      default: ext = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle data-memory access unit with a req/ack bus.
// Checks legality/alignment, builds byte enables and replicated store data,
// holds the core via Stall_o and registers the extended load result.
//   clk, reset                 clock, async active-high reset
//   Mem_Read_i/Mem_Write_i     load/store request from control path
//   Funct3_i, Address_i        access type and byte address
//   Write_Data_i               store data (rs2)
//   Stall_o                    freezes the PC while an access is pending
//   Load_Data_o                extended load result to the write-back mux
//   Access_Fault_o             misaligned/illegal access flag (IDLE only)
//   Bus_*                      data bus request channel and response
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned NBits = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Mem_Read_i,
  input  logic             Mem_Write_i,
  input  logic [2:0]       Funct3_i,
  input  logic [NBits-1:0] Address_i,
  input  logic [NBits-1:0] Write_Data_i,
  output logic             Stall_o,
  output logic [NBits-1:0] Load_Data_o,
  output logic             Access_Fault_o,
  output logic             Bus_Req_o,
  output logic             Bus_We_o,
  output logic [NBits-1:0] Bus_Addr_o,
  output logic [NBits-1:0] Bus_Wdata_o,
  output logic [3:0]       Bus_Be_o,
  input  logic             Bus_Ack_i,
  input  logic [NBits-1:0] Bus_Rdata_i
);

  lsu_state_e       state_q, state_d;
  logic [NBits-1:0] addr_q, wdata_q, load_q;
  logic [3:0]       be_q;
  logic             we_q;
  logic [2:0]       f3_q;

  logic             f3_ok, aligned, legal, accept;
  logic [3:0]       be_d;
  logic [NBits-1:0] wdata_d, ext_data;

  // Unsigned variants exist only for loads.
  always_comb begin
    case (Funct3_i)
      F3_B, F3_H, F3_W: f3_ok = 1'b1;
      F3_BU, F3_HU:     f3_ok = Mem_Read_i;
      default:          f3_ok = 1'b0;
    endcase
    case (Funct3_i)
      F3_H, F3_HU: aligned = ~Address_i[0];
      F3_W:        aligned = (Address_i[1:0] == 2'b00);
      default:     aligned = 1'b1;
    endcase
  end

  assign legal  = (Mem_Read_i ^ Mem_Write_i) & f3_ok & aligned;
  assign accept = (state_q == StIdle) & legal;

  assign Access_Fault_o = (state_q == StIdle) & (Mem_Read_i | Mem_Write_i) & ~legal;
  assign Stall_o        = (state_q == StReq) | accept;

  // Store lanes: funct3[1:0] gives the size for both signed and unsigned codes.
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = Write_Data_i;
    case (Funct3_i[1:0])
      2'b00: begin
        be_d    = 4'b0001 << Address_i[1:0];
        wdata_d = {4{Write_Data_i[7:0]}};
      end
      2'b01: begin
        be_d    = 4'b0011 << Address_i[1:0];
        wdata_d = {2{Write_Data_i[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = Write_Data_i;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StReq;
      StReq:   if (Bus_Ack_i) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  load_extender u_load_extender (
    .rdata  (Bus_Rdata_i),
    .off    (addr_q[1:0]),
    .funct3 (f3_q),
    .ext    (ext_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= Address_i;
        wdata_q <= wdata_d;
        be_q    <= be_d;
        we_q    <= Mem_Write_i;
        f3_q    <= Funct3_i;
      end
      if ((state_q == StReq) && Bus_Ack_i && !we_q) begin
        load_q <= ext_data;
      end
    end
  end

  // Bus_Req_o decodes straight from the state flop so reset drops it at once.
  assign Bus_Req_o   = (state_q == StReq);
  assign Bus_We_o    = we_q;
  assign Bus_Addr_o  = {addr_q[NBits-1:2], 2'b00};
  assign Bus_Wdata_o = wdata_q;
  assign Bus_Be_o    = be_q;
  assign Load_Data_o = load_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk, reset;
  logic        Mem_Read_i, Mem_Write_i;
  logic [2:0]  Funct3_i;
  logic [31:0] Address_i, Write_Data_i;
  logic        Stall_o, Access_Fault_o, Bus_Req_o, Bus_We_o, Bus_Ack_i;
  logic [31:0] Load_Data_o, Bus_Addr_o, Bus_Wdata_o, Bus_Rdata_i;
  logic [3:0]  Bus_Be_o;

  load_store_unit #(.NBits(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .Mem_Read_i     (Mem_Read_i),
    .Mem_Write_i    (Mem_Write_i),
    .Funct3_i       (Funct3_i),
    .Address_i      (Address_i),
    .Write_Data_i   (Write_Data_i),
    .Stall_o        (Stall_o),
    .Load_Data_o    (Load_Data_o),
    .Access_Fault_o (Access_Fault_o),
    .Bus_Req_o      (Bus_Req_o),
    .Bus_We_o       (Bus_We_o),
    .Bus_Addr_o     (Bus_Addr_o),
    .Bus_Wdata_o    (Bus_Wdata_o),
    .Bus_Be_o       (Bus_Be_o),
    .Bus_Ack_i      (Bus_Ack_i),
    .Bus_Rdata_i    (Bus_Rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endfunction

  // Expected outputs, maintained by the transaction-level model below.
  logic        check_en = 1'b0;
  logic        exp_stall = 1'b0, exp_fault = 1'b0, exp_req = 1'b0, exp_we = 1'b0;
  logic [31:0] exp_addr = '0, exp_wdata = '0, exp_load = '0;
  logic [3:0]  exp_be = '0;

  // Running tallies and last observed bus request, owned by the compare process.
  int          stall_tot = 0, fault_tot = 0, req_tot = 0;
  logic [31:0] seen_addr = '0, seen_wdata = '0;
  logic [3:0]  seen_be = '0;
  logic        seen_we = 1'b0;

  always @(negedge clk) begin
    if (check_en) begin
      check("stall", 32'(Stall_o), 32'(exp_stall));
      check("fault", 32'(Access_Fault_o), 32'(exp_fault));
      check("bus_req", 32'(Bus_Req_o), 32'(exp_req));
      check("load_data", Load_Data_o, exp_load);
      if (exp_req) begin
        check("bus_addr", Bus_Addr_o, exp_addr);
        check("bus_we", 32'(Bus_We_o), 32'(exp_we));
        check("bus_be", 32'(Bus_Be_o), 32'(exp_be));
        if (exp_we) check("bus_wdata", Bus_Wdata_o, exp_wdata);
      end
    end
    stall_tot += int'(Stall_o);
    fault_tot += int'(Access_Fault_o);
    req_tot   += int'(Bus_Req_o);
    if (Bus_Req_o) begin
      seen_addr  = Bus_Addr_o;
      seen_wdata = Bus_Wdata_o;
      seen_be    = Bus_Be_o;
      seen_we    = Bus_We_o;
    end
  end

  // ---- Reference rules ----
  function automatic bit m_legal(input bit rd, input bit wr, input logic [2:0] f3,
                                 input logic [31:0] a);
    bit ok;
    if (rd == wr) return 1'b0;
    ok = rd ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
    if (f3 == 3'd1 || f3 == 3'd5) ok = ok && (a % 2 == 0);
    if (f3 == 3'd2) ok = ok && (a % 4 == 0);
    return ok;
  endfunction

  function automatic int m_size(input logic [2:0] f3);
    return (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int n = m_size(f3);
    int mask = ((1 << n) - 1) << (a % 4);
    return 4'(mask);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    int n = m_size(f3);
    if (n == 1) return (d & 32'hFF) * 32'h0101_0101;
    if (n == 2) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] rdata);
    int n = m_size(f3);
    longint v = longint'((rdata >> (8 * (a % 4))) & ((n == 1) ? 32'hFF : 32'hFFFF));
    if (n == 4) return rdata;
    if (f3 == 3'd0 && v > 127) v -= 256;
    if (f3 == 3'd1 && v > 32767) v -= 65536;
    return 32'(v);
  endfunction

  // One instruction starting in an IDLE cycle (called at posedge+1);
  // returns at posedge+1 of the following IDLE cycle.
  task automatic do_acc(input bit rd, input bit wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] rdat, input int waits, input bit drop);
    bit ok = m_legal(rd, wr, f3, a);
    Mem_Read_i   = rd;
    Mem_Write_i  = wr;
    Funct3_i     = f3;
    Address_i    = a;
    Write_Data_i = d;
    Bus_Ack_i    = 1'($urandom % 2);
    Bus_Rdata_i  = $urandom;
    exp_fault    = (rd | wr) & !ok;
    exp_stall    = ok;
    exp_req      = 1'b0;
    @(posedge clk); #1;
    if (!ok) begin
      Mem_Read_i = 1'b0; Mem_Write_i = 1'b0; Bus_Ack_i = 1'b0;
      exp_fault = 1'b0; exp_stall = 1'b0;
      return;
    end
    exp_req   = 1'b1;
    exp_addr  = a & 32'hFFFF_FFFC;
    exp_we    = wr;
    exp_be    = m_be(f3, a);
    exp_wdata = m_wdata(f3, d);
    Bus_Ack_i = 1'b0;
    if (drop) begin
      Mem_Read_i = 1'b0; Mem_Write_i = 1'b0;
    end
    repeat (waits) begin
      @(posedge clk); #1;
    end
    Bus_Ack_i   = 1'b1;
    Bus_Rdata_i = rdat;
    @(posedge clk); #1;
    exp_req   = 1'b0;
    exp_stall = 1'b0;
    if (rd) exp_load = m_load(f3, a, rdat);
    Bus_Ack_i   = 1'($urandom % 2);
    Bus_Rdata_i = $urandom;
    @(posedge clk); #1;
    Mem_Read_i = 1'b0; Mem_Write_i = 1'b0; Bus_Ack_i = 1'b0;
  endtask

  int s0, f0, r0;
  logic [2:0]  flt_f3 [4] = '{3'd2, 3'd1, 3'd6, 3'd2};
  logic [31:0] flt_a  [4] = '{32'h101, 32'h3, 32'h0, 32'h0};
  bit          flt_wr [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  logic [2:0]  pick_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  initial begin
    reset = 1'b1;
    Mem_Read_i = 1'b0; Mem_Write_i = 1'b0; Funct3_i = '0;
    Address_i = '0; Write_Data_i = '0; Bus_Ack_i = 1'b0; Bus_Rdata_i = '0;
    #7;
    check("rst_load", Load_Data_o, 32'h0);
    check("rst_req", 32'(Bus_Req_o), 32'h0);
    check("rst_addr", Bus_Addr_o, 32'h0);
    check("rst_be_we_wdata", {Bus_Wdata_o[27:0], Bus_Be_o}, {28'h0, 4'h0});
    check("rst_we", 32'(Bus_We_o), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    check_en = 1'b1;

    // LW aligned, two ack-wait cycles.
    s0 = stall_tot;
    do_acc(1, 0, 3'd2, 32'h100, 32'h0, 32'hDEAD_BEEF, 2, 0);
    check("lw_stall_cycles", 32'(stall_tot - s0), 32'd4);
    check("lw_addr", seen_addr, 32'h100);
    check("lw_be", 32'(seen_be), 32'hF);
    check("lw_data", Load_Data_o, 32'hDEAD_BEEF);

    do_acc(1, 0, 3'd0, 32'h103, 32'h0, 32'h8011_2233, 0, 0);
    check("lb_addr", seen_addr, 32'h100);
    check("lb_data", Load_Data_o, 32'hFFFF_FF80);
    do_acc(1, 0, 3'd4, 32'h103, 32'h0, 32'h8011_2233, 1, 0);
    check("lbu_data", Load_Data_o, 32'h0000_0080);

    do_acc(0, 1, 3'd1, 32'h202, 32'h1234_ABCD, 32'h0, 1, 0);
    check("sh_be", 32'(seen_be), 32'hC);
    check("sh_wdata", seen_wdata, 32'hABCD_ABCD);
    check("sh_we", 32'(seen_we), 32'h1);
    check("sh_load_kept", Load_Data_o, 32'h0000_0080);

    for (int i = 0; i < 4; i++) begin
      s0 = stall_tot; f0 = fault_tot; r0 = req_tot;
      do_acc(1, flt_wr[i], flt_f3[i], flt_a[i], 32'h0, 32'h0, 0, 0);
      check("fault_cycles", 32'(fault_tot - f0), 32'd1);
      check("fault_no_req", 32'(req_tot - r0), 32'd0);
      check("fault_no_stall", 32'(stall_tot - s0), 32'd0);
    end

    // Back-to-back SW then LHU, both acked in the first REQ cycle.
    s0 = stall_tot;
    do_acc(0, 1, 3'd2, 32'h8, 32'h5566_7788, 32'h0, 0, 0);
    check("b2b_sw_stall", 32'(stall_tot - s0), 32'd2);
    s0 = stall_tot;
    do_acc(1, 0, 3'd5, 32'h6, 32'h0, 32'hF00D_0000, 0, 0);
    check("b2b_lhu_stall", 32'(stall_tot - s0), 32'd2);
    check("b2b_lhu_data", Load_Data_o, 32'h0000_F00D);

    // Reset asserted mid-REQ, before any ack.
    Mem_Read_i = 1'b1; Funct3_i = 3'd2; Address_i = 32'h400;
    exp_stall = 1'b1;
    @(posedge clk); #1;
    exp_req = 1'b1; exp_addr = 32'h400; exp_be = 4'hF; exp_we = 1'b0;
    @(posedge clk); #3;
    reset = 1'b1; Mem_Read_i = 1'b0;
    exp_req = 1'b0; exp_stall = 1'b0; exp_load = '0;
    #1;
    check("rst_mid_req_async", 32'(Bus_Req_o), 32'h0);
    check("rst_mid_stall", 32'(Stall_o), 32'h0);
    check("rst_mid_load", Load_Data_o, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    Bus_Ack_i = 1'b1; Bus_Rdata_i = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    Bus_Ack_i = 1'b0;
    check("late_ack_ignored", Load_Data_o, 32'h0);

    // Randomized instruction stream.
    for (int i = 0; i < 300; i++) begin
      int k = int'($urandom % 10);
      bit rd, wr;
      logic [2:0] f3;
      if (k == 0) begin
        Bus_Ack_i = 1'($urandom % 2); Bus_Rdata_i = $urandom;
        @(posedge clk); #1;
        Bus_Ack_i = 1'b0;
      end else begin
        rd = (k <= 5) || (k == 9);
        wr = (k > 5);
        f3 = ($urandom % 4 == 0) ? 3'($urandom) : pick_f3[$urandom % 5];
        do_acc(rd, wr, f3, $urandom, $urandom, $urandom, int'($urandom % 4),
               1'($urandom % 4 == 0));
      end
    end

    check_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
